// File: rtl/ibex_cap_pkg.sv
// ibex_cap_pkg: shared capability constants and the load-writeback state encoding.
// Contents: CAP_W / CAP_TAG_BIT geometry, NULLCAP and ALMIGHTY encodings,
// and cap_ld_state_e for ibex_cap_load_wb.
package ibex_cap_pkg;
    localparam int unsigned CAP_W       = 93;
    localparam int unsigned CAP_TAG_BIT = 92;
    localparam logic [CAP_W-1:0] NULLCAP  = 93'h000000000000001F690003F0;
    localparam logic [CAP_W-1:0] ALMIGHTY = 93'h100000000003FFDF690003F0;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BEAT0   = 3'd1,
        BEAT1   = 3'd2,
        BEAT2   = 3'd3,
        WB_PEND = 3'd4
    } cap_ld_state_e;
endpackage

// File: rtl/ibex_cap_load_wb.sv
// ibex_cap_load_wb: assembles capability/integer loads and merges them with the ALU onto the RF write port.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   ld_req_i, ld_cap_i, ld_waddr_i     load request from the LSU (cap = 3 beats, integer = 1 beat)
//   ld_req_ready_o                     idle, a request is accepted
//   data_rvalid_i/rdata_i/tag_i/err_i  data-bus beats (tag sampled on beat 0)
//   alu_we_i, alu_waddr_i, alu_wdata_i ALU writeback, always has port priority
//   rf_we_o, rf_waddr_o, rf_wdata_o    register-file write port
//   ld_busy_o, ld_waddr_o              outstanding load and its destination for the hazard unit
//   ld_done_o                          load written (or x0 write suppressed) this cycle
//   ld_err_o                           registered pulse, load aborted by a bus error
module ibex_cap_load_wb
    import ibex_cap_pkg::*;
#(
    parameter int unsigned DataWidth = 93,
    parameter int unsigned TagBit    = 92
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ld_req_i,
    input  logic                 ld_cap_i,
    input  logic [4:0]           ld_waddr_i,
    output logic                 ld_req_ready_o,
    input  logic                 data_rvalid_i,
    input  logic [31:0]          data_rdata_i,
    input  logic                 data_tag_i,
    input  logic                 data_err_i,
    input  logic                 alu_we_i,
    input  logic [4:0]           alu_waddr_i,
    input  logic [DataWidth-1:0] alu_wdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 ld_busy_o,
    output logic [4:0]           ld_waddr_o,
    output logic                 ld_done_o,
    output logic                 ld_err_o
);
    if (DataWidth != CAP_W || TagBit != CAP_TAG_BIT) begin : g_bad_width
        $error("ibex_cap_load_wb supports only DataWidth=93, TagBit=92");
    end

    cap_ld_state_e        r_state;
    logic                 r_cap;
    logic                 r_tag;
    logic                 r_err;
    logic [4:0]           r_waddr;
    logic [DataWidth-1:0] r_buf;
    logic                 w_in_beat;
    logic                 w_abort;
    logic                 w_ld_wb;

    assign w_in_beat = (r_state == BEAT0) || (r_state == BEAT1) || (r_state == BEAT2);
    assign w_abort   = w_in_beat && data_rvalid_i && data_err_i;
    // The load only reaches the port in cycles the ALU leaves free.
    assign w_ld_wb   = (r_state == WB_PEND) && !alu_we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cap   <= 1'b0;
            r_tag   <= 1'b0;
            r_err   <= 1'b0;
            r_waddr <= 5'd0;
            r_buf   <= NULLCAP;
        end else begin
            r_err <= 1'b0;
            if (w_abort) begin
                r_err   <= 1'b1;
                r_buf   <= NULLCAP;
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (ld_req_i) begin
                        r_cap   <= ld_cap_i;
                        r_waddr <= ld_waddr_i;
                        r_state <= BEAT0;
                    end
                    BEAT0: if (data_rvalid_i) begin
                        if (r_cap) begin
                            r_buf[31:0] <= data_rdata_i;
                            r_tag       <= data_tag_i;
                            r_state     <= BEAT1;
                        end else begin
                            r_buf   <= {NULLCAP[DataWidth-1:32], data_rdata_i};
                            r_state <= WB_PEND;
                        end
                    end
                    BEAT1: if (data_rvalid_i) begin
                        r_buf[63:32] <= data_rdata_i;
                        r_state      <= BEAT2;
                    end
                    // Top nibble of the last beat lies beyond the 93-bit capability.
                    BEAT2: if (data_rvalid_i) begin
                        r_buf[91:64]  <= data_rdata_i[27:0];
                        r_buf[TagBit] <= r_tag;
                        r_state       <= WB_PEND;
                    end
                    WB_PEND: if (!alu_we_i) r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rf_we_o    = alu_we_i ? (alu_waddr_i != 5'd0) : (w_ld_wb && r_waddr != 5'd0);
        rf_waddr_o = alu_we_i ? alu_waddr_i : (w_ld_wb ? r_waddr : 5'd0);
        rf_wdata_o = alu_we_i ? alu_wdata_i : (w_ld_wb ? r_buf : '0);
    end

    assign ld_req_ready_o = (r_state == IDLE);
    assign ld_busy_o      = (r_state != IDLE);
    assign ld_waddr_o     = ld_busy_o ? r_waddr : 5'd0;
    assign ld_done_o      = w_ld_wb;
    assign ld_err_o       = r_err;
endmodule

// File: tb/tb_ibex_cap_load_wb.sv
// tb_ibex_cap_load_wb: directed self-checking bench for ibex_cap_load_wb.
module tb_ibex_cap_load_wb;
    localparam logic [92:0] NULLCAP  = 93'h000000000000001F690003F0;
    localparam logic [92:0] ALMIGHTY = 93'h100000000003FFDF690003F0;
    localparam logic [92:0] UNTAGGED = 93'h000000000003FFDF690003F0;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ld_req_i = 1'b0;
    logic        ld_cap_i = 1'b0;
    logic [4:0]  ld_waddr_i = 5'd0;
    logic        ld_req_ready_o;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;
    logic        data_tag_i = 1'b0;
    logic        data_err_i = 1'b0;
    logic        alu_we_i = 1'b0;
    logic [4:0]  alu_waddr_i = 5'd0;
    logic [92:0] alu_wdata_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [92:0] rf_wdata_o;
    logic        ld_busy_o;
    logic [4:0]  ld_waddr_o;
    logic        ld_done_o;
    logic        ld_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    ibex_cap_load_wb dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ld_req_i(ld_req_i), .ld_cap_i(ld_cap_i), .ld_waddr_i(ld_waddr_i),
        .ld_req_ready_o(ld_req_ready_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_tag_i(data_tag_i), .data_err_i(data_err_i),
        .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .ld_busy_o(ld_busy_o), .ld_waddr_o(ld_waddr_o),
        .ld_done_o(ld_done_o), .ld_err_o(ld_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [92:0] obs, input logic [92:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic cap, input logic [4:0] addr);
        ld_req_i = 1'b1; ld_cap_i = cap; ld_waddr_i = addr;
        step();
        ld_req_i = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic tag, input logic err);
        data_rvalid_i = 1'b1; data_rdata_i = d; data_tag_i = tag; data_err_i = err;
        step();
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_ready", ld_req_ready_o, 1);
        chk("rst_we", rf_we_o, 0);
        chk("rst_waddr", rf_waddr_o, 0);
        chk("rst_wdata", rf_wdata_o, 0);
        chk("rst_busy", ld_busy_o, 0);
        chk("rst_ldwaddr", ld_waddr_o, 0);
        chk("rst_done", ld_done_o, 0);
        chk("rst_err", ld_err_o, 0);
        step();
        rst_ni = 1'b1;
        step();

        // capability load to x5, upper nibble of beat 2 must be dropped
        req(1, 5);
        chk("cap_busy", ld_busy_o, 1);
        chk("cap_ldwaddr", ld_waddr_o, 5);
        chk("cap_ready", ld_req_ready_o, 0);
        beat(32'h690003F0, 1, 0);
        beat(32'h0003FFDF, 0, 0);
        chk("cap_no_early_we", rf_we_o, 0);
        beat(32'hF0000000, 0, 0);
        chk("cap_we", rf_we_o, 1);
        chk("cap_waddr", rf_waddr_o, 5);
        chk("cap_wdata", rf_wdata_o, ALMIGHTY);
        chk("cap_done", ld_done_o, 1);
        step();
        chk("cap_idle_we", rf_we_o, 0);
        chk("cap_idle_done", ld_done_o, 0);
        chk("cap_idle_ready", ld_req_ready_o, 1);

        // integer load to x7
        req(0, 7);
        beat(32'hDEADBEEF, 1, 0);
        chk("int_we", rf_we_o, 1);
        chk("int_waddr", rf_waddr_o, 7);
        chk("int_wdata", rf_wdata_o, 93'h1F_DEADBEEF);
        chk("int_tag", rf_wdata_o[92], 0);
        step();

        // capability load to x3 delayed by two ALU writes to x9
        req(1, 3);
        beat(32'h690003F0, 1, 0);
        beat(32'h0003FFDF, 0, 0);
        beat(32'h00000000, 0, 0);
        alu_we_i = 1'b1; alu_waddr_i = 5'd9; alu_wdata_i = 93'h123;
        #1;
        chk("alu1_we", rf_we_o, 1);
        chk("alu1_waddr", rf_waddr_o, 9);
        chk("alu1_wdata", rf_wdata_o, 93'h123);
        chk("alu1_done", ld_done_o, 0);
        chk("alu1_busy", ld_busy_o, 1);
        step();
        chk("alu2_waddr", rf_waddr_o, 9);
        chk("alu2_wdata", rf_wdata_o, 93'h123);
        chk("alu2_busy", ld_busy_o, 1);
        alu_we_i = 1'b0;
        #1;
        chk("late_we", rf_we_o, 1);
        chk("late_waddr", rf_waddr_o, 3);
        chk("late_wdata", rf_wdata_o, ALMIGHTY);
        chk("late_done", ld_done_o, 1);
        step();
        chk("late_busy", ld_busy_o, 0);

        // bus error on beat 1
        req(1, 4);
        beat(32'h690003F0, 1, 0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h0003FFDF; data_err_i = 1'b1;
        #1;
        chk("err_cycle_we", rf_we_o, 0);
        chk("err_cycle_pulse", ld_err_o, 0);
        step();
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
        chk("err_pulse", ld_err_o, 1);
        chk("err_ready", ld_req_ready_o, 1);
        chk("err_we", rf_we_o, 0);
        chk("err_busy", ld_busy_o, 0);
        step();
        chk("err_pulse_end", ld_err_o, 0);
        req(0, 8);
        beat(32'h12345678, 0, 0);
        chk("post_err_waddr", rf_waddr_o, 8);
        chk("post_err_wdata", rf_wdata_o, 93'h1F_12345678);
        chk("post_err_done", ld_done_o, 1);
        step();

        // capability load to x0
        req(1, 0);
        beat(32'h690003F0, 1, 0);
        beat(32'h0003FFDF, 0, 0);
        beat(32'h00000000, 0, 0);
        chk("x0_we", rf_we_o, 0);
        chk("x0_done", ld_done_o, 1);
        step();
        chk("x0_ready", ld_req_ready_o, 1);

        // reset mid-load, then an untagged load
        req(1, 6);
        beat(32'h11111111, 1, 0);
        beat(32'h22222222, 0, 0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_busy", ld_busy_o, 0);
        chk("mid_rst_ready", ld_req_ready_o, 1);
        chk("mid_rst_we", rf_we_o, 0);
        rst_ni = 1'b1;
        step();
        req(1, 6);
        beat(32'h690003F0, 0, 0);
        beat(32'h0003FFDF, 1, 0);
        beat(32'h00000000, 1, 0);
        chk("fresh_we", rf_we_o, 1);
        chk("fresh_waddr", rf_waddr_o, 6);
        chk("fresh_wdata", rf_wdata_o, UNTAGGED);
        chk("fresh_tag", rf_wdata_o[92], 0);
        step();
        chk("fresh_idle", ld_busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
